// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the wait-stated memory responder.
package mem_pkg;
    localparam int ADDR_W_DEF   = 12;
    localparam int DATA_W_DEF   = 16;
    localparam int WAIT_CYC_DEF = 2;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/mem_responder_if.sv
// CPU-side request/acknowledge bus between a bus master and mem_responder.
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              REQ;
    logic              WE;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] WDATA;
    logic [DATA_W-1:0] RDATA;
    logic              ACK;
    logic              BUSY;

    modport master (output REQ, WE, ADDR, WDATA, input RDATA, ACK, BUSY);
    modport slave  (input REQ, WE, ADDR, WDATA, output RDATA, ACK, BUSY);
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous storage; the read register is resettable, the array is not.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] store [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en && we) store[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          rdata <= '0;
        else if (en && !we)  rdata <= store[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// Request/ack memory responder: captures a request, inserts WAIT_CYC wait states,
// performs one array access and pulses ACK for one cycle.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic            clk,
    input  logic            REST_N,
    mem_responder_if.slave  bus
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               mem_en;

    always_ff @(posedge clk or negedge REST_N) begin
        if (!REST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // ACCESS spans an address-setup cycle and a strobe cycle; the array is only
    // enabled on the strobe cycle, so an earlier reset leaves it untouched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mem_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ) begin
                    we_d    = bus.WE;
                    addr_d  = bus.ADDR;
                    wdata_d = bus.WDATA;
                    cnt_d   = CNT_W'(WAIT_CYC);
                    state_d = (WAIT_CYC == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                phase_d = 1'b1;
                if (phase_q) begin
                    mem_en  = 1'b1;
                    phase_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk   (clk),
        .rst_n (REST_N),
        .en    (mem_en),
        .we    (we_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (bus.RDATA)
    );

    assign bus.ACK  = (state_q == ST_DONE);
    assign bus.BUSY = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (WAIT_CYC=2 and WAIT_CYC=0) driven with directed and random traffic.
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic REST_N = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(12), .DATA_W(16)) bus2 ();
    mem_responder_if #(.ADDR_W(12), .DATA_W(16)) bus0 ();

    mem_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_CYC(2)) u_w2 (.clk(clk), .REST_N(REST_N), .bus(bus2.slave));
    mem_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_CYC(0)) u_w0 (.clk(clk), .REST_N(REST_N), .bus(bus0.slave));

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [15:0] data;
        int          cap;
        int          ack_at;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] mm0[int];
    logic [15:0] mm1[int];
    int          wa0[$];
    int          wa1[$];
    logic [15:0] rd_m[2];
    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, int d, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0h expected %0h at cycle %0d", nm, d, act, exp, cyc);
        end
    endtask

    function automatic logic get_ack(int d);  return (d == 0) ? bus2.ACK  : bus0.ACK;  endfunction
    function automatic logic get_busy(int d); return (d == 0) ? bus2.BUSY : bus0.BUSY; endfunction
    function automatic logic [15:0] get_rd(int d); return (d == 0) ? bus2.RDATA : bus0.RDATA; endfunction

    task automatic drv(int d, logic r, logic w, logic [11:0] a, logic [15:0] wd);
        if (d == 0) begin bus2.REQ = r; bus2.WE = w; bus2.ADDR = a; bus2.WDATA = wd; end
        else        begin bus0.REQ = r; bus0.WE = w; bus0.ADDR = a; bus0.WDATA = wd; end
    endtask

    function automatic logic [15:0] mem_rd(int d, logic [11:0] a);
        if (d == 0) return mm0.exists(int'(a)) ? mm0[int'(a)] : 16'h0;
        return mm1.exists(int'(a)) ? mm1[int'(a)] : 16'h0;
    endfunction

    task automatic mem_wr(int d, logic [11:0] a, logic [15:0] v);
        if (d == 0) begin if (!mm0.exists(int'(a))) wa0.push_back(int'(a)); mm0[int'(a)] = v; end
        else        begin if (!mm1.exists(int'(a))) wa1.push_back(int'(a)); mm1[int'(a)] = v; end
    endtask

    // Monitor: BUSY must span capture..ACK of the outstanding request; RDATA moves only on read ACK.
    task automatic mon(int d);
        exp_t e;
        bit   have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (d == 0) ? q0[0] : q1[0];
        check("busy", d, 32'(get_busy(d)), 32'(have && (cyc >= e.cap)));
        if (get_ack(d)) begin
            check("ack_expected", d, 32'(get_ack(d)), 32'(have));
            if (have) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                check("ack_latency", d, 32'(cyc), 32'(e.ack_at));
                if (!e.we) rd_m[d] = e.data;
            end
            check("rdata_ack", d, 32'(get_rd(d)), 32'(rd_m[d]));
        end else begin
            check("rdata_hold", d, 32'(get_rd(d)), 32'(rd_m[d]));
        end
    endtask

    always @(negedge clk) begin
        if (REST_N) begin
            for (int d = 0; d < 2; d++) mon(d);
        end
    end

    task automatic pulse_reset();
        #2;
        REST_N = 1'b0;
        q0.delete();
        q1.delete();
        rd_m[0] = 16'h0;
        rd_m[1] = 16'h0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ack", d, 32'(get_ack(d)), 32'h0);
            check("rst_busy", d, 32'(get_busy(d)), 32'h0);
            check("rst_rdata", d, 32'(get_rd(d)), 32'h0);
            drv(d, 1'b0, 1'b0, 12'h0, 16'h0);
        end
        repeat (2) @(negedge clk);
        #2 REST_N = 1'b1;
        @(negedge clk);
    endtask

    // Called on a negedge. from_done: previous txn left REQ high and the DUT sits in DONE.
    task automatic txn(int d, bit we, logic [11:0] a, logic [15:0] wd,
                       bit from_done, bit keep_req, bit scramble, bit abort);
        exp_t e;
        int   w;
        int   t;
        w        = (d == 0) ? 2 : 0;
        e.we     = we;
        e.addr   = a;
        e.cap    = cyc + (from_done ? 2 : 1);
        e.ack_at = e.cap + w + 2;
        if (we) begin
            e.data = wd;
            if (!abort) mem_wr(d, a, wd);
        end else begin
            e.data = mem_rd(d, a);
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        drv(d, 1'b1, we, a, wd);
        while (cyc < e.cap) @(negedge clk);
        if (abort) begin
            pulse_reset();
            return;
        end
        if (scramble) drv(d, 1'b1, ~we, a ^ 12'h001, ~wd);
        t = 0;
        while (!get_ack(d) && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (!get_ack(d)) begin
            check("ack_timeout", d, 32'(get_ack(d)), 32'h1);
            if (d == 0) q0.delete(); else q1.delete();
            drv(d, 1'b0, 1'b0, 12'h0, 16'h0);
            repeat (2) @(negedge clk);
            return;
        end
        if (!keep_req) begin
            drv(d, 1'b0, 1'(($urandom)), 12'($urandom), 16'($urandom));
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a;
        int          d;
        bit          kr;
        rd_m[0] = 16'h0;
        rd_m[1] = 16'h0;
        drv(0, 1'b0, 1'b0, 12'h0, 16'h0);
        drv(1, 1'b0, 1'b0, 12'h0, 16'h0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("init_ack", i, 32'(get_ack(i)), 32'h0);
            check("init_busy", i, 32'(get_busy(i)), 32'h0);
            check("init_rdata", i, 32'(get_rd(i)), 32'h0);
        end
        #2 REST_N = 1'b1;
        @(negedge clk);

        // write then read, both wait settings
        txn(0, 1'b1, 12'h005, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        txn(1, 1'b1, 12'h00A, 16'hCAFE, 1'b0, 1'b0, 1'b0, 1'b0);
        txn(1, 1'b0, 12'h00A, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // address extremes
        for (int i = 0; i < 2; i++) begin
            txn(i, 1'b1, 12'hFFF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
            txn(i, 1'b1, 12'h000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
            txn(i, 1'b0, 12'hFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
            txn(i, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // inputs changed after capture must not matter
        for (int i = 0; i < 2; i++) begin
            txn(i, 1'b1, 12'h020, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
            txn(i, 1'b1, 12'h021, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
            txn(i, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
            txn(i, 1'b1, 12'h020, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b0);
            txn(i, 1'b0, 12'h021, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
            txn(i, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // REQ held through DONE becomes a new request
        txn(0, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        txn(0, 1'b0, 12'hFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        txn(1, 1'b0, 12'h00A, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        txn(1, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset during WAIT aborts the write; array survives reset
        txn(0, 1'b1, 12'h010, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b1, 12'h010, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b1);
        txn(0, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // random traffic
        for (int n = 0; n < 150; n++) begin
            d  = int'($urandom_range(0, 1));
            kr = 1'b0;
            for (int k = 0; k < 2; k++) begin
                bit rd_op;
                bit next_kr;
                rd_op   = ($urandom_range(0, 1) == 1) && ((d == 0) ? wa0.size() > 0 : wa1.size() > 0);
                next_kr = (k == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (rd_op) begin
                    a = (d == 0) ? 12'(wa0[$urandom_range(0, wa0.size() - 1)])
                                 : 12'(wa1[$urandom_range(0, wa1.size() - 1)]);
                    txn(d, 1'b0, a, 16'($urandom), kr, next_kr, 1'($urandom_range(0, 1)), 1'b0);
                end else begin
                    case ($urandom_range(0, 3))
                        0:       a = 12'h000;
                        1:       a = 12'hFFF;
                        default: a = 12'($urandom);
                    endcase
                    txn(d, 1'b1, a, 16'($urandom), kr, next_kr, 1'($urandom_range(0, 1)), 1'b0);
                end
                kr = next_kr;
            end
        end

        // final reset while idle with non-zero RDATA
        pulse_reset();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
